// File: rtl/core_pkg.sv
// Shared types for the unified memory port arbiter.
// Holds FSM states, owner encoding and access width codes.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

endpackage

// File: rtl/arb_prio.sv
// Winner select for the I/D requesters.
// D wins by default; a starvation counter forces I through.
module arb_prio
  import core_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic d_req,
  input  logic take,
  output logic sel_i,
  output logic sel_d
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [3:0] cnt;

  // I wins when D is idle or I has waited out the limit
  always_comb begin
    sel_i = i_req & (~d_req | (cnt == LIM));
    sel_d = d_req & ~sel_i;
  end

  // count D grants taken while I is waiting, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (take) begin
      if (sel_i || !i_req) begin
        cnt <= '0;
      end else if (sel_d && cnt != LIM) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I-fetch and D-access.
// One outstanding transaction; responses go to the owner only.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_width,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [1:0]        m_width,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  arb_state_t        state;
  logic              owner;
  logic              we_q;
  logic [1:0]        width_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic take;
  logic sel_i;
  logic sel_d;
  logic done;
  logic rd_done;

  arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk  (clk),
    .rst  (rst),
    .i_req(i_req),
    .d_req(d_req),
    .take (take),
    .sel_i(sel_i),
    .sel_d(sel_d)
  );

  // grants, completion detection and response routing
  always_comb begin
    take     = ~rst & (state == IDLE) & (i_req | d_req);
    i_gnt    = take & sel_i;
    d_gnt    = take & sel_d;
    rd_done  = ~rst & (state == WAIT) & m_rvalid;
    done     = rd_done | (~rst & (state == REQ) & m_ready & we_q);
    i_rvalid = done & (owner == OWN_I);
    d_rvalid = done & (owner == OWN_D);
    i_rdata  = (i_rvalid && rd_done) ? m_rdata : '0;
    d_rdata  = (d_rvalid && rd_done) ? m_rdata : '0;
    m_req    = (state == REQ);
    m_we     = we_q;
    m_addr   = addr_q;
    m_wdata  = wdata_q;
    m_width  = width_q;
    busy     = (state != IDLE);
  end

  // transaction FSM with request capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= OWN_I;
      we_q    <= 1'b0;
      width_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            state <= REQ;
            if (sel_i) begin
              owner   <= OWN_I;
              we_q    <= 1'b0;
              width_q <= W_WORD;
              addr_q  <= i_addr;
              wdata_q <= '0;
            end else begin
              owner   <= OWN_D;
              we_q    <= d_we;
              width_q <= d_width;
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
            end
          end
        end
        REQ: begin
          if (m_ready) begin
            state <= we_q ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (m_rvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Inputs change on negedge; outputs checked 1ns later.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_width;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [1:0]  m_width;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        busy;

  int total;
  int passed;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_gnt   (i_gnt),
    .i_rvalid(i_rvalid),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_width (d_width),
    .d_gnt   (d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata (d_rdata),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_width (m_width),
    .m_ready (m_ready),
    .m_rvalid(m_rvalid),
    .m_rdata (m_rdata),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] v;
    rst = 1'b1;
    d_req = 1'b1;
    settle();
    v = {i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we, busy};
    total++;
    if (v !== 7'b0 || m_addr !== 32'h0 || d_rdata !== 32'h0)
      $display("FAIL reset_outputs got %b addr %h need 0", v, m_addr);
    else passed++;
    nxt();
    d_req = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_d_read();
    d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h1001_0004; d_width = 2'b10;
    settle();
    total++;
    if ({d_gnt, i_gnt, busy} !== 3'b100)
      $display("FAIL t1_gnt got %b need 100", {d_gnt, i_gnt, busy});
    else passed++;
    nxt();
    d_req = 1'b0; m_ready = 1'b1;
    settle();
    total++;
    if (m_req !== 1'b1 || m_addr !== 32'h1001_0004 || m_we !== 1'b0 || d_rvalid !== 1'b0)
      $display("FAIL t1_mreq got req %b addr %h we %b", m_req, m_addr, m_we);
    else passed++;
    nxt();
    m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
    settle();
    total++;
    if ({d_rvalid, i_rvalid} !== 2'b10 || d_rdata !== 32'hDEAD_BEEF || i_rdata !== 32'h0)
      $display("FAIL t1_rvalid got %b data %h need 10 deadbeef", {d_rvalid, i_rvalid}, d_rdata);
    else passed++;
    nxt();
    m_rvalid = 1'b0; m_rdata = '0;
    settle();
    total++;
    if (busy !== 1'b0 || i_rvalid !== 1'b0)
      $display("FAIL t1_idle got busy %b need 0", busy);
    else passed++;
  endtask

  task automatic test_d_write();
    d_req = 1'b1; d_we = 1'b1;
    d_addr = 32'h2000_0008; d_wdata = 32'h1234_5678; d_width = 2'b10;
    settle();
    total++;
    if (d_gnt !== 1'b1)
      $display("FAIL t2_gnt got %b need 1", d_gnt);
    else passed++;
    nxt();
    d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    for (int c = 1; c <= 2; c++) begin
      m_rvalid = (c == 2);
      m_rdata = 32'h5555_AAAA;
      settle();
      total++;
      if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h2000_0008 ||
          m_wdata !== 32'h1234_5678 || m_width !== 2'b10 || d_rvalid !== 1'b0 || d_gnt !== 1'b0)
        $display("FAIL t2_hold c%0d got req %b we %b addr %h wd %h rv %b",
                 c, m_req, m_we, m_addr, m_wdata, d_rvalid);
      else passed++;
      nxt();
    end
    m_rvalid = 1'b0; m_ready = 1'b1;
    settle();
    total++;
    if (m_req !== 1'b1 || d_rvalid !== 1'b1 || d_rdata !== 32'h0 || i_rvalid !== 1'b0)
      $display("FAIL t2_ack got req %b rv %b data %h need 1 1 0", m_req, d_rvalid, d_rdata);
    else passed++;
    nxt();
    m_ready = 1'b0;
    settle();
    total++;
    if (busy !== 1'b0 || m_req !== 1'b0 || d_rvalid !== 1'b0)
      $display("FAIL t2_idle got busy %b req %b need 0 0", busy, m_req);
    else passed++;
  endtask

  task automatic test_priority();
    i_req = 1'b1; i_addr = 32'h0000_0400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000_0000; d_width = 2'b00;
    settle();
    total++;
    if ({i_gnt, d_gnt} !== 2'b01)
      $display("FAIL t3_dfirst got %b need 01", {i_gnt, d_gnt});
    else passed++;
    nxt();
    d_req = 1'b0; m_ready = 1'b1;
    settle();
    total++;
    if (i_gnt !== 1'b0 || m_req !== 1'b1 || m_width !== 2'b00)
      $display("FAIL t3_busy got ignt %b req %b w %b", i_gnt, m_req, m_width);
    else passed++;
    nxt();
    m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0BAD_F00D;
    settle();
    total++;
    if ({i_rvalid, d_rvalid} !== 2'b01 || i_rdata !== 32'h0)
      $display("FAIL t3_drsp got %b idata %h need 01 0", {i_rvalid, d_rvalid}, i_rdata);
    else passed++;
    nxt();
    m_rvalid = 1'b0;
    settle();
    total++;
    if ({i_gnt, d_gnt} !== 2'b10)
      $display("FAIL t3_igrant got %b need 10", {i_gnt, d_gnt});
    else passed++;
    nxt();
    i_req = 1'b0; m_ready = 1'b1;
    settle();
    total++;
    if (m_req !== 1'b1 || m_addr !== 32'h0000_0400 || m_we !== 1'b0 || m_width !== 2'b10)
      $display("FAIL t3_imreq got addr %h we %b w %b", m_addr, m_we, m_width);
    else passed++;
    nxt();
    m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D;
    settle();
    total++;
    if ({i_rvalid, d_rvalid} !== 2'b10 || i_rdata !== 32'hCAFE_F00D || d_rdata !== 32'h0)
      $display("FAIL t3_irsp got %b data %h need 10 cafef00d", {i_rvalid, d_rvalid}, i_rdata);
    else passed++;
    nxt();
    m_rvalid = 1'b0;
  endtask

  task automatic test_starvation();
    logic [9:0] exp_i;
    exp_i = 10'b1000010000;
    i_req = 1'b1; i_addr = 32'h0000_0800;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000_0000;
    m_ready = 1'b1; m_rvalid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      m_rdata = 32'(k) + 32'hA0;
      settle();
      total++;
      if ({i_gnt, d_gnt} !== {exp_i[k], ~exp_i[k]})
        $display("FAIL t4_grant%0d got %b need %b", k, {i_gnt, d_gnt}, {exp_i[k], ~exp_i[k]});
      else passed++;
      nxt();
      settle();
      total++;
      if ({i_gnt, d_gnt, i_rvalid, d_rvalid, m_req} !== 5'b00001)
        $display("FAIL t4_req%0d got %b need 00001", k, {i_gnt, d_gnt, i_rvalid, d_rvalid, m_req});
      else passed++;
      nxt();
      settle();
      total++;
      if ({i_rvalid, d_rvalid} !== {exp_i[k], ~exp_i[k]} ||
          (exp_i[k] ? i_rdata : d_rdata) !== 32'(k) + 32'hA0)
        $display("FAIL t4_rsp%0d got %b need %b", k, {i_rvalid, d_rvalid}, {exp_i[k], ~exp_i[k]});
      else passed++;
      nxt();
    end
    i_req = 1'b0; d_req = 1'b0;
    m_ready = 1'b0; m_rvalid = 1'b0;
  endtask

  task automatic test_reset_wait();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000_0010; d_width = 2'b01;
    settle();
    total++;
    if (d_gnt !== 1'b1)
      $display("FAIL t5_gnt got %b need 1", d_gnt);
    else passed++;
    nxt();
    d_req = 1'b0; m_ready = 1'b1;
    nxt();
    m_ready = 1'b0; rst = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h7777_7777;
    settle();
    total++;
    if ({i_rvalid, d_rvalid} !== 2'b00 || d_rdata !== 32'h0)
      $display("FAIL t5_norsp got %b data %h need 00 0", {i_rvalid, d_rvalid}, d_rdata);
    else passed++;
    nxt();
    rst = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    settle();
    total++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we, busy} !== 7'b0 ||
        m_addr !== 32'h0 || m_width !== 2'b00 || m_wdata !== 32'h0)
      $display("FAIL t5_cleared got busy %b req %b addr %h need 0", busy, m_req, m_addr);
    else passed++;
  endtask

  initial begin
    total = 0; passed = 0;
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_width = '0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    repeat (2) @(posedge clk);
    nxt();
    test_reset();
    test_d_read();
    nxt();
    test_d_write();
    nxt();
    test_priority();
    test_starvation();
    test_reset_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
